piso: RTL and testbench

PISO -- requirements
Module: piso

---
 rtl/piso.sv | 83 ++++++++
 tb/tb_piso.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// Parallel-in serial-out shifter with valid/ready load handshake and clock enable.
// Define PISO_LSB_FIRST_EN to send elements least-significant first (default MSB first).
module piso #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [LENGTH*WIDTH-1:0] i_par,
  output logic                    o_ready,
  output logic [WIDTH-1:0]        o_ser,
  output logic                    o_valid,
  output logic                    o_first,
  output logic                    o_last
);
  localparam int TW = LENGTH * WIDTH;
  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            at_last;
  logic            xfer;
  logic [WIDTH-1:0] head;
  logic [TW-1:0]   advanced;

`ifdef PISO_LSB_FIRST_EN
  assign head     = sreg_q[WIDTH-1:0];
  assign advanced = sreg_q >> WIDTH;
`else
  assign head     = sreg_q[TW-1 -: WIDTH];
  assign advanced = sreg_q << WIDTH;
`endif

  assign at_last = (cnt_q == LAST);
  assign o_ready = (state_q == IDLE) || at_last;
  assign xfer    = i_valid && o_ready && i_en;

  assign o_valid = (state_q == SHIFT);
  assign o_ser   = o_valid ? head : '0;
  assign o_first = o_valid && (cnt_q == '0);
  assign o_last  = o_valid && at_last;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (i_en) begin
      // A load on the final element wins over the return to IDLE, so words abut.
      if (xfer) begin
        state_d = SHIFT;
        sreg_d  = i_par;
        cnt_d   = '0;
      end else if (state_q == SHIFT) begin
        if (at_last) begin
          state_d = IDLE;
          sreg_d  = '0;
          cnt_d   = '0;
        end else begin
          sreg_d = advanced;
          cnt_d  = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: table-driven single words plus hand sequences for
// back-to-back, enable gating, reset corners and a WIDTH=2 loopback receiver.
module tb_piso;
  logic       clk = 1'b0;
  logic       rst, en, valid;
  logic [3:0] par;
  logic       ready, ser, ovalid, first, last;

  logic       lb_valid;
  logic [5:0] lb_par;
  logic       lb_ready, lb_ovalid, lb_first, lb_last;
  logic [1:0] lb_ser;
  logic [5:0] rx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(1), .LENGTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_par(par),
    .o_ready(ready), .o_ser(ser), .o_valid(ovalid), .o_first(first), .o_last(last)
  );

  piso #(.WIDTH(2), .LENGTH(3)) u_lb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(lb_valid), .i_par(lb_par),
    .o_ready(lb_ready), .o_ser(lb_ser), .o_valid(lb_ovalid), .o_first(lb_first), .o_last(lb_last)
  );

  // Shift-in-at-LSB receiver sharing the enable
  always @(posedge clk) begin
    if (rst) rx <= '0;
    else if (en) rx <= {rx[3:0], lb_ser};
  end

  typedef struct {
    logic [3:0] par;
    logic [3:0] seq;  // seq[3] is the first element expected on o_ser
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, {7'd0, ovalid}, 8'd0);
    chk({tag, " ser"},   {7'd0, ser},    8'd0);
    chk({tag, " first"}, {7'd0, first},  8'd0);
    chk({tag, " last"},  {7'd0, last},   8'd0);
    chk({tag, " ready"}, {7'd0, ready},  8'd1);
  endtask

  initial begin
    logic [7:0] seq8;
    logic [3:0] seq4;
`ifdef PISO_LSB_FIRST_EN
    vecs[0] = '{4'b1011, 4'b1101};
    vecs[1] = '{4'b0110, 4'b0110};
    vecs[2] = '{4'b1000, 4'b0001};
    vecs[3] = '{4'b0001, 4'b1000};
    vecs[4] = '{4'b1111, 4'b1111};
    seq8 = 8'b0101_1010;
    seq4 = 4'b0011;
`else
    vecs[0] = '{4'b1011, 4'b1011};
    vecs[1] = '{4'b0110, 4'b0110};
    vecs[2] = '{4'b1000, 4'b1000};
    vecs[3] = '{4'b0001, 4'b0001};
    vecs[4] = '{4'b1111, 4'b1111};
    seq8 = 8'b1010_0101;
    seq4 = 4'b1100;
`endif
    rst = 1'b1; en = 1'b0; valid = 1'b0; par = '0; lb_valid = 1'b0; lb_par = '0;
    step(); step();
    rst = 1'b0;
    chk_idle("reset");

    // Table: load, then change i_par mid-word to prove it is ignored
    foreach (vecs[v]) begin
      en = 1'b1; valid = 1'b1; par = vecs[v].par;
      step();
      valid = 1'b0; par = ~vecs[v].par;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d e%0d ser", v, k),   {7'd0, ser},    {7'd0, vecs[v].seq[3-k]});
        chk($sformatf("v%0d e%0d valid", v, k), {7'd0, ovalid}, 8'd1);
        chk($sformatf("v%0d e%0d first", v, k), {7'd0, first},  {7'd0, k == 0});
        chk($sformatf("v%0d e%0d last", v, k),  {7'd0, last},   {7'd0, k == 3});
        chk($sformatf("v%0d e%0d ready", v, k), {7'd0, ready},  {7'd0, k == 3});
        step();
      end
      chk_idle($sformatf("v%0d end", v));
    end

    // Back-to-back A then 5 with i_valid held
    en = 1'b1; valid = 1'b1; par = 4'hA;
    step();
    par = 4'h5;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b %0d ser", k),   {7'd0, ser},    {7'd0, seq8[7-k]});
      chk($sformatf("b2b %0d valid", k), {7'd0, ovalid}, 8'd1);
      chk($sformatf("b2b %0d first", k), {7'd0, first},  {7'd0, (k % 4) == 0});
      step();
      if (k == 3) valid = 1'b0;
    end
    chk_idle("b2b end");

    // Enable gating: each element held two cycles, word takes 8 cycles
    en = 1'b1; valid = 1'b1; par = 4'b1100;
    step();
    valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("gate %0d ser", j),   {7'd0, ser},    {7'd0, seq4[3 - j/2]});
      chk($sformatf("gate %0d valid", j), {7'd0, ovalid}, 8'd1);
      chk($sformatf("gate %0d ready", j), {7'd0, ready},  {7'd0, (j/2) == 3});
      en = (j % 2 == 1);
      step();
    end
    chk_idle("gate end");

    // Reset mid-word on the 2nd element
    en = 1'b1; valid = 1'b1; par = 4'b1011;
    step();
    valid = 1'b0;
    step();
    chk("rst mid e1 valid", {7'd0, ovalid}, 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst mid");
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst mid after %0d valid", k), {7'd0, ovalid}, 8'd0);
    end

    // Reset beats a simultaneous transfer, even with i_en low
    en = 1'b0; valid = 1'b1; par = 4'hF; rst = 1'b1;
    step();
    en = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    chk_idle("rst vs xfer");

    // Loopback through the WIDTH=2 LENGTH=3 instance
    en = 1'b1; lb_valid = 1'b1; lb_par = 6'b110110;
    step();
    lb_valid = 1'b0; lb_par = '0;
    chk("lb first", {7'd0, lb_first}, 8'd1);
    step(); step(); step();
`ifdef PISO_LSB_FIRST_EN
    chk("lb rx", {2'd0, rx}, 8'b0010_0111);
`else
    chk("lb rx", {2'd0, rx}, 8'b0011_0110);
`endif
    chk("lb idle valid", {7'd0, lb_ovalid}, 8'd0);
    chk("lb idle ready", {7'd0, lb_ready},  8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
